// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 block and next-PC logic.
//   - CP0 register numbers (Count, Compare, SR, Cause, EPC, PrID)
//   - SR/Cause field bit positions
//   - interrupt handler vector
//   - word-align helper used for EPC loads
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    localparam logic [31:0] HANDLER_VEC = 32'h0000_4180;

    // EPC always holds a word address.
    function automatic logic [31:0] align_word(input logic [31:0] x);
        return x & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with sticky timer-pending bit.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   we, addr, din  - already-qualified mtc0 write (squashed writes never reach here)
//   count, compare - current register values for mfc0 reads
//   tp             - timer pending, ORed into the top interrupt line
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        tp
);

    logic [31:0] count_q, compare_q;
    logic        tp_q;
    logic        match;

    assign match   = (count_q == compare_q);
    assign count   = count_q;
    assign compare = compare_q;
    // Include the live match so the interrupt fires in the cycle Count reads Compare.
    assign tp      = tp_q | match;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            tp_q      <= 1'b0;
        end else begin
            // A software write to Count replaces this cycle's increment.
            if (we && addr == REG_COUNT) count_q <= din;
            else                         count_q <= count_q + 32'd1;

            if (we && addr == REG_COMPARE) begin
                compare_q <= din;
                tp_q      <= 1'b0;
            end else if (match) begin
                tp_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 exception/interrupt state (SR, Cause, EPC, PrID).
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   pc        - PC of the executing instruction (resume address on interrupt)
//   addr, din, we - mfc0/mtc0 register number, write data, write enable
//   EXLClr    - eret executing, clears EXL
//   HWInt     - level-sensitive device interrupt lines
//   IntReq    - take interrupt this cycle (next-PC jumps to HANDLER_VEC)
//   epc       - EPC value for eret
//   dout      - mfc0 read data
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID     = 32'h0000_0001,
    parameter int unsigned HW_INT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic [4:0]          addr,
    input  logic [31:0]         din,
    input  logic                we,
    input  logic                EXLClr,
    input  logic [HW_INT_W-1:0] HWInt,
    output logic                IntReq,
    output logic [31:0]         epc,
    output logic [31:0]         dout
);

    logic [HW_INT_W-1:0] im_q, im_d;
    logic [HW_INT_W-1:0] ip_q, ip_d;
    logic                ie_q, ie_d;
    logic                exl_q, exl_d;
    logic [31:0]         epc_q, epc_d;
    logic [HW_INT_W-1:0] hw_eff;
    logic                wr_ok;
    logic [31:0]         sr_val, cause_val;

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;
    logic        tp;

    cp0_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_ok),
        .addr    (addr),
        .din     (din),
        .count   (count),
        .compare (compare),
        .tp      (tp)
    );
`endif

    always_comb begin
        hw_eff = HWInt;
`ifdef CP0_TIMER_EN
        hw_eff[HW_INT_W-1] = HWInt[HW_INT_W-1] | tp;
`endif
        IntReq = (|(hw_eff & im_q)) & ie_q & ~exl_q & ~EXLClr & ~rst;
        // The interrupted instruction is abandoned, so its mtc0 never lands.
        wr_ok  = we & ~IntReq;

        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;
        ip_d  = hw_eff;

        if (IntReq) begin
            epc_d = align_word(pc);
            exl_d = 1'b1;
        end else begin
            if (EXLClr) exl_d = 1'b0;
            if (wr_ok && addr == REG_SR) begin
                im_d  = din[IM_LO +: HW_INT_W];
                ie_d  = din[IE_BIT];
                // eret in the same cycle still wins over a written EXL=1.
                exl_d = din[EXL_BIT] & ~EXLClr;
            end
            if (wr_ok && addr == REG_EPC) epc_d = align_word(din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q  <= '0;
            ip_q  <= '0;
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            ip_q  <= ip_d;
            ie_q  <= ie_d;
            exl_q <= exl_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        sr_val                      = '0;
        sr_val[IM_LO +: HW_INT_W]   = im_q;
        sr_val[EXL_BIT]             = exl_q;
        sr_val[IE_BIT]              = ie_q;
        cause_val                   = '0;
        cause_val[IM_LO +: HW_INT_W] = ip_q;

        dout = '0;
        case (addr)
            REG_SR:      dout = sr_val;
            REG_CAUSE:   dout = cause_val;
            REG_EPC:     dout = epc_q;
            REG_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
            REG_COUNT:   dout = count;
            REG_COMPARE: dout = compare;
`endif
            default:     dout = '0;
        endcase
    end

    assign epc = epc_q;

endmodule
